// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-serial sequencer of the RAM port for the I-fetch and D sides
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_busy,
    output logic              i_done,
    output logic [31:0]       i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_len,
    input  logic [31:0]       d_wdata,
    output logic              d_busy,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    input  logic [7:0]        mem_din,
    input  logic              io_buffer_full,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state_q, state_d;
    logic i_pend_q, i_pend_d, d_pend_q, d_pend_d, d_we_q, d_we_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d, mem_a_q, mem_a_d, na;
    logic [2:0] d_len_q, d_len_d, len_q, len_d;
    logic [31:0] d_wdata_q, d_wdata_d, wdata_q, wdata_d, buf_q, buf_d, nbuf;
    logic [31:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic last_q, last_d, side_q, side_d;
    logic [1:0] k_q, k_d, kn;
    logic mem_wr_q, mem_wr_d, i_done_q, i_done_d, d_done_q, d_done_d;
    logic [7:0] mem_dout_q, mem_dout_d;
    logic ip, gnt_d, last_byte;

    function automatic logic io_stall(input logic [ADDR_W-1:0] a, input logic full);
        return a[17:16] == IO_HI && full;
    endfunction

    assign i_busy   = i_pend_q | (state_q != IDLE && !side_q);
    assign d_busy   = d_pend_q | (state_q != IDLE && side_q);
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign i_data   = i_data_q;
    assign d_rdata  = d_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;

    // next state: request capture, arbitration, byte sequencing, flush
    always_comb begin
        state_d    = state_q;
        i_pend_d   = i_pend_q;
        i_addr_d   = i_addr_q;
        d_pend_d   = d_pend_q;
        d_we_d     = d_we_q;
        d_addr_d   = d_addr_q;
        d_len_d    = d_len_q;
        d_wdata_d  = d_wdata_q;
        last_d     = last_q;
        side_d     = side_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        k_d        = k_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        i_data_d   = i_data_q;
        d_rdata_d  = d_rdata_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        ip         = i_pend_q & ~clr;
        gnt_d      = d_pend_q & (~ip | ~last_q);
        last_byte  = {1'b0, k_q} == len_q - 3'd1;
        kn         = k_q + 2'd1;
        na         = mem_a_q + ADDR_W'(1);
        nbuf       = buf_q | (32'(mem_din) << {k_q, 3'b000});
        case (state_q)
            IDLE: if (ip | d_pend_q) begin
                side_d     = gnt_d;
                last_d     = gnt_d;
                k_d        = 2'd0;
                buf_d      = '0;
                mem_a_d    = gnt_d ? d_addr_q : i_addr_q;
                len_d      = gnt_d ? d_len_q : 3'd4;
                wdata_d    = d_wdata_q;
                mem_dout_d = d_wdata_q[7:0];
                d_pend_d   = d_pend_q & ~gnt_d;
                i_pend_d   = i_pend_q & gnt_d;
                state_d    = (gnt_d && d_we_q) ? WRITE : READ;
                mem_wr_d   = gnt_d && d_we_q && !io_stall(d_addr_q, io_buffer_full);
            end
            READ: if (clr && !side_q) begin
                state_d = IDLE;
            end else if (last_byte) begin
                state_d   = IDLE;
                d_done_d  = side_q;
                i_done_d  = !side_q;
                d_rdata_d = side_q ? nbuf : d_rdata_q;
                i_data_d  = side_q ? i_data_q : nbuf;
            end else begin
                k_d     = kn;
                mem_a_d = na;
                buf_d   = nbuf;
            end
            WRITE: if (!mem_wr_q) begin
                mem_wr_d = !io_stall(mem_a_q, io_buffer_full);
            end else if (last_byte) begin
                mem_wr_d = 1'b0;
                d_done_d = 1'b1;
                state_d  = IDLE;
            end else begin
                k_d        = kn;
                mem_a_d    = na;
                mem_dout_d = 8'(wdata_q >> {kn, 3'b000});
                mem_wr_d   = !io_stall(na, io_buffer_full);
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            i_pend_d = 1'b0;
        end else if (i_req && !i_busy) begin
            i_pend_d = 1'b1;
            i_addr_d = i_addr;
        end
        if (d_req && !d_busy) begin
            d_pend_d  = 1'b1;
            d_we_d    = d_we;
            d_addr_d  = d_addr;
            d_len_d   = d_len;
            d_wdata_d = d_wdata;
        end
    end

    // state registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_pend_q   <= 1'b0;
            i_addr_q   <= '0;
            d_pend_q   <= 1'b0;
            d_we_q     <= 1'b0;
            d_addr_q   <= '0;
            d_len_q    <= '0;
            d_wdata_q  <= '0;
            last_q     <= 1'b0;
            side_q     <= 1'b0;
            len_q      <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            k_q        <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            i_data_q   <= '0;
            d_rdata_q  <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            i_pend_q   <= i_pend_d;
            i_addr_q   <= i_addr_d;
            d_pend_q   <= d_pend_d;
            d_we_q     <= d_we_d;
            d_addr_q   <= d_addr_d;
            d_len_q    <= d_len_d;
            d_wdata_q  <= d_wdata_d;
            last_q     <= last_d;
            side_q     <= side_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            k_q        <= k_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            i_data_q   <= i_data_d;
            d_rdata_q  <= d_rdata_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for tie, flush and rdy freeze
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst, rdy, clr, i_req, i_busy, i_done, d_req, d_we, d_busy, d_done;
    logic io_buffer_full, mem_wr;
    logic [31:0] i_addr, i_data, d_addr, d_wdata, d_rdata, mem_a;
    logic [2:0] d_len;
    logic [7:0] mem_din, mem_dout;
    logic [7:0] ram [4096];

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        int          full;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl [8];

    int tests = 0, fails = 0, n, it, dt, ic, dc, wn;
    logic [31:0] iv, dv, wa [8];
    logic [7:0] wd [8];

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_done(i_done), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .d_busy(d_busy), .d_done(d_done), .d_rdata(d_rdata),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ix(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    assign mem_din = ram[ix(mem_a)];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic clr_obs();
        n = 0; it = -1; dt = -1; ic = 0; dc = 0; wn = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (i_done) begin ic++; it = n; iv = i_data; end
        if (d_done) begin dc++; dt = n; dv = d_rdata; end
        if (mem_wr && wn < 8) begin wa[wn] = mem_a; wd[wn] = mem_dout; wn++; end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] sh;
        io_buffer_full = v.full > 0;
        if (v.d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_len = v.len; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        step();
        clr_obs();
        i_req = 1'b0;
        d_req = 1'b0;
        while ((v.d ? dc : ic) == 0 && n < 30) begin
            step();
            io_buffer_full = n < v.full;
            if (!v.we && n <= int'(v.len)) chk("rd_addr", mem_a, v.addr + n - 1);
            if (v.d ? d_done : i_done) begin
                chk("busy_at_done", v.d ? d_busy : i_busy, 0);
                chk("wr_at_done", mem_wr, 0);
            end
        end
        chk("latency", n, v.lat);
        chk("other_done", v.d ? ic : dc, 0);
        if (v.we) begin
            chk("wr_count", wn, v.len);
            for (int j = 0; j < wn; j++) begin
                sh = v.wdata >> (8 * j);
                chk("wr_addr", wa[j], v.addr + j);
                chk("wr_byte", wd[j], sh[7:0]);
            end
        end else begin
            chk("rdata", v.d ? dv : iv, v.exp);
        end
    endtask

    task automatic tie(input bit d_first);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_len = 3'd2;
        i_req = 1'b1; i_addr = 32'h100;
        step();
        clr_obs();
        d_req = 1'b0;
        i_req = 1'b0;
        while ((ic == 0 || dc == 0) && n < 30) step();
        chk("tie_d_time", dt, d_first ? 3 : 8);
        chk("tie_i_time", it, d_first ? 8 : 5);
        chk("tie_d_data", dv, 32'h0000BBAA);
        chk("tie_i_data", iv, 32'h44332211);
        chk("tie_counts", {ic[7:0], dc[7:0]}, 16'h0101);
    endtask

    initial begin
        tbl[0] = '{0, 0, 32'h100,   3'd4, 32'h0,        0, 32'h44332211, 5};
        tbl[1] = '{1, 0, 32'h200,   3'd2, 32'h0,        0, 32'h0000BBAA, 3};
        tbl[2] = '{1, 1, 32'h300,   3'd4, 32'hDEADBEEF, 0, 32'h0,        5};
        tbl[3] = '{1, 1, 32'h30000, 3'd1, 32'h0000005A, 3, 32'h0,        5};
        tbl[4] = '{1, 0, 32'h200,   3'd4, 32'h0,        0, 32'hDDCCBBAA, 5};
        tbl[5] = '{1, 0, 32'h203,   3'd1, 32'h0,        0, 32'h000000DD, 2};
        tbl[6] = '{1, 1, 32'h310,   3'd2, 32'h12345678, 0, 32'h0,        3};
        tbl[7] = '{0, 0, 32'h200,   3'd4, 32'h0,        0, 32'hDDCCBBAA, 5};
        for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
        ram[ix(32'h100)] = 8'h11; ram[ix(32'h101)] = 8'h22;
        ram[ix(32'h102)] = 8'h33; ram[ix(32'h103)] = 8'h44;
        ram[ix(32'h200)] = 8'hAA; ram[ix(32'h201)] = 8'hBB;
        ram[ix(32'h202)] = 8'hCC; ram[ix(32'h203)] = 8'hDD;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_len = '0; d_wdata = '0; io_buffer_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {i_busy, d_busy}, 0);
        chk("rst_done", {i_done, d_done}, 0);
        chk("rst_i_data", i_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        step();
        chk("idle_mem_a", mem_a, 0);
        for (int v = 0; v < 8; v++) run_vec(tbl[v]);
        tie(1'b1);
        run_vec(tbl[5]);
        tie(1'b0);
        // flush on the 3rd byte of a fetch while a D load waits
        i_req = 1'b1; i_addr = 32'h100;
        step();
        clr_obs();
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_len = 3'd2;
        step();
        d_req = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_i_busy", i_busy, 0);
        while (dc == 0 && n < 30) step();
        chk("clr_d_time", dt, 7);
        chk("clr_d_data", dv, 32'h0000BBAA);
        chk("clr_no_i_done", ic, 0);
        chk("clr_i_data_hold", i_data, 32'h44332211);
        // flush on the final fetch byte
        i_req = 1'b1; i_addr = 32'h200;
        step();
        clr_obs();
        i_req = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (2) step();
        chk("clr_last_no_done", ic, 0);
        chk("clr_last_busy", i_busy, 0);
        // flush together with a fetch request
        i_req = 1'b1; clr = 1'b1;
        step();
        clr_obs();
        i_req = 1'b0; clr = 1'b0;
        chk("clr_req_busy", i_busy, 0);
        repeat (6) step();
        chk("clr_req_no_done", ic, 0);
        // rdy low for two cycles mid load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_len = 3'd4;
        step();
        clr_obs();
        d_req = 1'b0;
        step();
        step();
        chk("rdy_mem_a_pre", mem_a, 32'h201);
        rdy = 1'b0;
        step();
        chk("rdy_mem_a_f1", mem_a, 32'h201);
        step();
        chk("rdy_mem_a_f2", mem_a, 32'h201);
        rdy = 1'b1;
        while (dc == 0 && n < 30) step();
        chk("rdy_latency", dt, 7);
        chk("rdy_data", dv, 32'hDDCCBBAA);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port of the CPU between two requesters: the instruction-fetch side (I, read-only) and the data side (D, the dcache path serving the store/load buffer).
- Each request moves 1, 2 or 4 bytes as a sequence of byte cycles.
- Responses return on per-side done/data outputs, tagged only by side.
- Provides fair round-robin arbitration, a flush for the I side, rdy freeze, and write stall on a full IO buffer.

Parameters:
ADDR_W, 32, address width
IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state and outputs
clr  in  1  pipeline flush; cancels I-side work only
i_req  in  1  I fetch request pulse (always 4-byte read)
i_addr  in  ADDR_W  I fetch address
i_busy  out  1  I request pending or in progress
i_done  out  1  one-cycle pulse, fetch complete
i_data  out  32  fetched word, little-endian
d_req  in  1  D request pulse
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  D address
d_len  in  3  byte count: 1, 2 or 4
d_wdata  in  32  store data; low d_len bytes used
d_busy  out  1  D request pending or in progress
d_done  out  1  one-cycle pulse, load/store complete
d_rdata  out  32  load data, zero-extended
mem_din  in  8  RAM read byte; valid the cycle after its address
io_buffer_full  in  1  IO write buffer full
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1 = write

Behaviour:
- Reset (rst high at an edge): all outputs 0, both pending slots empty, state IDLE, byte counter 0, last-grant = I (so D wins the first tie).
- rdy low: nothing changes.
  - No request pulses are sampled and counters do not advance.
  - Requesters hold pulses until rdy returns.
- Request capture:
  - A req high at an edge latches addr/len/we/wdata into that side's pending slot.
  - A req on a side whose busy is high is a protocol violation (ignored, flagged by the bench).
  - busy rises the cycle after req and falls in the same cycle done pulses.
- States: IDLE, READ, WRITE.
- IDLE:
  - If exactly one slot is pending, grant it.
  - If both are pending, grant the side not granted last.
  - Grant edge: mem_a = base addr, k = 0; next state READ or WRITE; the slot moves to active.
  - Nothing pending: mem_wr = 0, mem_a holds.
- READ, length L:
  - At each edge with k < L-1: mem_a = base+k+1.
  - At edges 1..L after the grant edge, mem_din is captured into byte k.
  - At the edge capturing byte L-1: done pulses with the full data, unused high bytes 0, state IDLE.
  - Total latency from req edge to done visible: L+1 edges. A 4-byte fetch is done 5 edges after req.
- WRITE, length L:
  - The grant edge drives mem_wr = 1, mem_a = base, mem_dout = byte0.
  - Each following edge advances k.
  - After byte L-1 has been driven for one cycle, the next edge sets mem_wr = 0, pulses done and returns to IDLE. Latency is L+1 edges.
  - IO stall: if addr[17:16] == IO_HI and io_buffer_full is high, the byte is not driven (mem_wr = 0, k holds) until io_buffer_full is low. The stall is checked per byte.
- clr high at an edge:
  - Clears the I pending slot and any i_req sampled that edge.
  - If the active transaction is I, it aborts: state IDLE, mem_wr = 0, no i_done.
  - D pending and active transactions are unaffected.
  - If clr coincides with the final I byte edge, i_done is suppressed.
- done pulses last exactly one cycle. The data outputs hold until the next done on that side.
- A requester may pulse req in the cycle its done is high.
- At most one transaction is active at a time. The two done signals are never both high.

Test Plan:
- Reset then idle: all outputs 0; i_req addr 0x100 with RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles; i_done after 5 edges with i_data = 0x44332211.
- d_req and i_req on the same edge after reset -> D (load, len 2, 0x200) granted first; d_done with d_rdata = 0x0000BBAA; I granted at the next IDLE edge. Repeat with both pending -> alternates.
- Store len 4, addr 0x300, data 0xDEADBEEF -> mem_wr high 4 cycles with bytes EF, BE, AD, DE at 0x300..0x303; d_done on the 5th edge after req.
- Store len 1 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then byte written; d_done 1 edge later.
- clr during the 3rd byte of an I fetch while a D load is pending -> no i_done, i_busy low next cycle, D load starts the following edge and completes normally.
- rdy low for 2 cycles mid D load -> mem_a and counter frozen; d_rdata correct; latency extended by exactly 2.
